// File: rtl/byte_encode.sv
// byte_encode: packs a frame of 256 d-bit coefficients into the
// ByteEncode_d byte stream (32*d bytes, LSB-first) through a 20-bit bit buffer.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. The input side uses i_valid/o_ready. The output side uses
// o_valid/i_ready. o_ready and o_valid depend only on registered state, never
// on the partner's valid or ready, so there is no combinational path between
// the two sides. Once o_valid is high, o_byte and o_last hold until the byte
// is taken.
module byte_encode (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [3:0]  i_d,
  input  logic [11:0] i_coeff,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [7:0]  o_byte,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_last,
  output logic        o_done,
  output logic        o_err,
  output logic        o_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [3:0]   d_q;
  logic [19:0]  buf_q;
  logic [4:0]   cnt_q;
  logic [8:0]   coeff_cnt_q;
  logic [8:0]   byte_cnt_q;
  logic         done_q;
  logic         err_q;

  logic         d_legal;
  logic         accept;
  logic         pop;
  logic [11:0]  mask;
  logic [19:0]  ins;
  logic [8:0]   last_idx;

  // Decode which widths form a legal frame.
  always_comb begin
    d_legal = 1'b0;
    case (i_d)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: d_legal = 1'b1;
      default:                               d_legal = 1'b0;
    endcase
  end

  // Handshake qualifiers, coefficient placement and final-byte index.
  // Accept and pop cannot coincide: accept needs cnt < 8, pop needs cnt >= 8.
  always_comb begin
    o_ready  = (state_q == RUN) && (cnt_q < 5'd8) && (coeff_cnt_q < 9'd256);
    o_valid  = (state_q == RUN) && (cnt_q >= 5'd8);
    accept   = o_ready && i_valid;
    pop      = o_valid && i_ready;
    mask     = (12'd1 << d_q) - 12'd1;
    ins      = {8'd0, i_coeff & mask} << cnt_q;
    last_idx = {d_q, 5'd0} - 9'd1;
    o_last   = o_valid && (byte_cnt_q == last_idx);
    o_byte   = buf_q[7:0];
    o_done   = done_q;
    o_err    = err_q;
    o_state  = (state_q == RUN);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: a legal start enters RUN, accepting the last byte returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start && d_legal) state_d = RUN;
      RUN:     if (pop && o_last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bit buffer, fill count, frame counters and the registered status pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      d_q         <= 4'd0;
      buf_q       <= 20'd0;
      cnt_q       <= 5'd0;
      coeff_cnt_q <= 9'd0;
      byte_cnt_q  <= 9'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= pop && o_last;
      err_q  <= (state_q == IDLE) && i_start && !d_legal;
      if (state_q == IDLE) begin
        if (i_start && d_legal) begin
          d_q         <= i_d;
          buf_q       <= 20'd0;
          cnt_q       <= 5'd0;
          coeff_cnt_q <= 9'd0;
          byte_cnt_q  <= 9'd0;
        end
      end else if (accept) begin
        buf_q       <= buf_q | ins;
        cnt_q       <= cnt_q + {1'b0, d_q};
        coeff_cnt_q <= coeff_cnt_q + 9'd1;
      end else if (pop) begin
        buf_q      <= buf_q >> 8;
        cnt_q      <= cnt_q - 5'd8;
        byte_cnt_q <= byte_cnt_q + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_byte_encode.sv
// tb_byte_encode: table-driven frames checked against a bit-level ByteEncode_d
// reference, plus hand-written sequences for the error and mid-frame reset cases.
module tb_byte_encode;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_rst, i_start, i_valid, i_ready;
  logic [3:0]  i_d;
  logic [11:0] i_coeff;
  logic        o_ready, o_valid, o_last, o_done, o_err, o_state;
  logic [7:0]  o_byte;

  byte_encode dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_d     (i_d),
    .i_coeff (i_coeff),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_byte  (o_byte),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_last  (o_last),
    .o_done  (o_done),
    .o_err   (o_err),
    .o_state (o_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  logic [11:0] coeffs [256];
  logic [7:0]  exp_q[$];
  logic [7:0]  got   [384];
  logic [7:0]  got10 [384];

  typedef struct {
    int         d;
    int         pat;
    logic [7:0] b0, b1, b2;
    int         nbytes;
    bit         check_head;
    bit         stall;
    bit         poke;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus patterns ----------------
  task automatic fill(input int pat);
    for (int j = 0; j < 256; j++) begin
      case (pat)
        0: coeffs[j] = 12'h001;
        1: coeffs[j] = 12'(j % 16);
        2: coeffs[j] = (j == 0) ? 12'h123 : (j == 1) ? 12'h456 : 12'h000;
        3: coeffs[j] = (j == 0) ? 12'h3FF : 12'h000;
        4: coeffs[j] = 12'hFF5;
        default: coeffs[j] = 12'($urandom_range(0, 4095));
      endcase
    end
  endtask

  // Reference: stream bit j*d+i is bit i of coefficient j; stream bit k is
  // bit k%8 of byte k/8. Upper coefficient bits never get addressed.
  task automatic build_model(input int d);
    logic [7:0] b;
    exp_q.delete();
    b = 8'd0;
    for (int k = 0; k < 256 * d; k++) begin
      b[k % 8] = coeffs[k / d][k % d];
      if (k % 8 == 7) begin
        exp_q.push_back(b);
        b = 8'd0;
      end
    end
  endtask

  // ---------------- driver + monitor ----------------
  // Inputs are driven and outputs sampled at the falling edge; o_ready/o_valid
  // come from registers, so a transfer seen here completes at the next rise.
  task automatic run_frame(input int d, input bit stall, input bit poke, output int nb);
    int  cidx, bidx, cyc;
    bit  done, rv, vv;
    @(negedge clk);
    i_start = 1'b1; i_d = 4'(d); i_valid = 1'b0; i_ready = 1'b0;
    @(negedge clk);
    i_start = 1'b0; i_d = 4'($urandom_range(0, 15));
    check("ready_after_start", o_ready, 1);
    check("state_run", o_state, 1);
    cidx = 0; bidx = 0; cyc = 0; done = 0;
    while (!done && cyc < 6000) begin
      rv = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      vv = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (cidx >= 256) vv = 1'b0;
      if (poke && cyc == 40) begin
        i_start = 1'b1; i_d = 4'd1;
      end else begin
        i_start = 1'b0;
      end
      i_valid = vv;
      i_coeff = vv ? coeffs[cidx] : 12'($urandom_range(0, 4095));
      i_ready = rv;
      if (o_valid && rv) begin
        if (bidx < 384) got[bidx] = o_byte;
        if (bidx < exp_q.size()) check($sformatf("byte[%0d]", bidx), o_byte, exp_q[bidx]);
        else                     check("byte_overrun", bidx, exp_q.size());
        check($sformatf("last[%0d]", bidx), o_last, (bidx == exp_q.size() - 1));
        if (o_last) done = 1;
        bidx++;
      end
      if (o_ready && vv) cidx++;
      @(negedge clk);
      cyc++;
    end
    i_valid = 1'b0; i_ready = 1'b0; i_start = 1'b0;
    check("frame_completed", done, 1);
    check("done_pulse", o_done, 1);
    check("idle_after_last", o_state, 0);
    check("no_valid_after_last", o_valid, 0);
    @(negedge clk);
    check("done_one_cycle", o_done, 0);
    nb = bidx;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, o_ready, 0);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_last"},  o_last,  0);
    check({tag, "_done"},  o_done,  0);
    check({tag, "_err"},   o_err,   0);
    check({tag, "_byte"},  o_byte,  0);
    check({tag, "_state"}, o_state, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int nb, cidx;
    int bad_d [4];

    tbl[0] = '{1,  0, 8'hFF, 8'hFF, 8'hFF, 32,  1, 0, 0};
    tbl[1] = '{4,  1, 8'h10, 8'h32, 8'h54, 128, 1, 0, 0};
    tbl[2] = '{4,  4, 8'h55, 8'h55, 8'h55, 128, 1, 1, 0};
    tbl[3] = '{12, 2, 8'h23, 8'h61, 8'h45, 384, 1, 0, 1};
    tbl[4] = '{10, 3, 8'hFF, 8'h03, 8'h00, 320, 1, 0, 0};
    tbl[5] = '{10, 3, 8'hFF, 8'h03, 8'h00, 320, 1, 1, 0};
    tbl[6] = '{5,  5, 8'h00, 8'h00, 8'h00, 160, 0, 1, 0};
    tbl[7] = '{11, 5, 8'h00, 8'h00, 8'h00, 352, 0, 0, 0};
    tbl[8] = '{12, 5, 8'h00, 8'h00, 8'h00, 384, 0, 1, 1};
    tbl[9] = '{1,  5, 8'h00, 8'h00, 8'h00, 32,  0, 1, 0};

    i_rst = 1'b1; i_start = 1'b0; i_d = 4'd0; i_coeff = 12'd0;
    i_valid = 1'b0; i_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    i_rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // Table-driven frames.
    for (int t = 0; t < 10; t++) begin
      fill(tbl[t].pat);
      build_model(tbl[t].d);
      run_frame(tbl[t].d, tbl[t].stall, tbl[t].poke, nb);
      check($sformatf("nbytes_t%0d", t), nb, tbl[t].nbytes);
      if (tbl[t].check_head) begin
        check($sformatf("head0_t%0d", t), got[0], tbl[t].b0);
        check($sformatf("head1_t%0d", t), got[1], tbl[t].b1);
        check($sformatf("head2_t%0d", t), got[2], tbl[t].b2);
      end
      if (t == 4) for (int k = 0; k < 320; k++) got10[k] = got[k];
      if (t == 5) for (int k = 0; k < 320; k++)
        check($sformatf("stall_same[%0d]", k), got[k], got10[k]);
    end

    // Illegal widths: error pulse, block stays idle.
    bad_d = '{7, 0, 2, 13};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_start = 1'b1; i_d = 4'(bad_d[k]);
      @(negedge clk);
      i_start = 1'b0;
      check($sformatf("err_pulse_d%0d", bad_d[k]), o_err, 1);
      check($sformatf("err_ready_d%0d", bad_d[k]), o_ready, 0);
      check($sformatf("err_state_d%0d", bad_d[k]), o_state, 0);
      @(negedge clk);
      check($sformatf("err_one_cycle_d%0d", bad_d[k]), o_err, 0);
      check($sformatf("err_ready2_d%0d", bad_d[k]), o_ready, 0);
    end
    fill(5);
    build_model(5);
    run_frame(5, 0, 0, nb);
    check("nbytes_after_err", nb, 160);

    // Reset after 100 accepted coefficients of a d=11 frame.
    fill(5);
    @(negedge clk);
    i_start = 1'b1; i_d = 4'd11;
    @(negedge clk);
    i_start = 1'b0;
    cidx = 0;
    for (int cyc = 0; cyc < 2000 && cidx < 100; cyc++) begin
      i_valid = 1'b1; i_ready = 1'b1; i_coeff = coeffs[cidx];
      if (o_ready) cidx++;
      @(negedge clk);
    end
    check("midreset_fed", cidx, 100);
    i_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    i_rst = 1'b0; i_ready = 1'b0;
    @(negedge clk);
    check_all_zero("midreset_release");
    fill(5);
    build_model(11);
    run_frame(11, 1, 0, nb);
    check("nbytes_after_reset", nb, 352);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
